// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared 640x400 VGA timing, sync polarity and RGB332 layout.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // Horizontal timing in pixel clocks: display, front porch, sync, back porch
    localparam int HDR = 640;
    localparam int HFP = 16;
    localparam int HSP = 96;
    localparam int HBP = 48;

    // Vertical timing in lines
    localparam int VDR = 400;
    localparam int VFP = 12;
    localparam int VSP = 2;
    localparam int VBP = 35;

    localparam logic HPL = 1'b0;
    localparam logic VPL = 1'b1;

    localparam int FB_W = 320;
    localparam int FB_H = 200;

    // RGB332 field positions within a framebuffer byte
    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    // Eight equal-width colour bars across the 640-pixel active line
    function automatic logic [2:0] bar_index(input logic [9:0] pix);
        return 3'(pix / 10'd80);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vga_delay_line
// Description : Fixed-depth shift register with a synchronous reset fill value.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_delay_line #(
    parameter int               WIDTH     = 1,
    parameter int               DEPTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_stage_q [DEPTH];
    logic [WIDTH-1:0] w_stage_d [DEPTH];

    always_comb begin
        w_stage_d[0] = i_data;
        for (int i = 1; i < DEPTH; i++) begin
            w_stage_d[i] = r_stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage_q[i] <= RESET_VAL;
            end
        end else begin
            r_stage_q <= w_stage_d;
        end
    end

    assign o_data = r_stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_fetch
// Description : Pixel-doubled 320x200 RGB332 framebuffer fetch with sync
//               alignment and a frame-latched colour-bar test mode.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_fetch #(
    parameter int   FB_W   = vga_pkg::FB_W,
    parameter int   FB_H   = vga_pkg::FB_H,
    parameter int   RD_LAT = 2,
    parameter logic HPL    = vga_pkg::HPL,
    parameter logic VPL    = vga_pkg::VPL
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [9:0]  pixelCnt,
    input  logic [8:0]  lineCnt,
    input  logic        hSync,
    input  logic        vSync,
    input  logic        compBlank,
    input  logic        testMode,
    output logic [15:0] memAddr,
    output logic        memRdEn,
    input  logic [7:0]  memData,
    output logic [2:0]  vgaRed,
    output logic [2:0]  vgaGreen,
    output logic [1:0]  vgaBlue,
    output logic        vgaHSync,
    output logic        vgaVSync,
    output logic        frameStart
);

    import vga_pkg::*;

    localparam int c_lat   = RD_LAT + 2;
    localparam int c_act_w = 2 * FB_W;
    localparam int c_act_h = 2 * FB_H;

    logic        w_visible;
    logic        w_start;
    logic        w_tm_eff;
    logic        w_tm_lat_d;
    logic [15:0] w_addr_calc;
    logic [15:0] w_addr_d;
    logic        w_rd_en_d;
    logic [2:0]  w_bar;

    logic        w_blank_dly;
    logic        w_tm_dly;
    logic [2:0]  w_bar_dly;

    logic [2:0]  w_red_d;
    logic [2:0]  w_green_d;
    logic [1:0]  w_blue_d;

    logic [15:0] r_mem_addr_q;
    logic        r_mem_rd_en_q;
    logic        r_tm_lat_q;
    logic [2:0]  r_red_q;
    logic [2:0]  r_green_q;
    logic [1:0]  r_blue_q;

    assign w_addr_calc = {8'd0, lineCnt[8:1]} * 16'(FB_W) + {7'd0, pixelCnt[9:1]};
    assign w_bar       = bar_index(pixelCnt);

    // The mode sampled at (0,0) already governs pixel (0,0) itself, so a frame
    // is rendered entirely in one mode.
    always_comb begin
        w_visible  = ~compBlank && (pixelCnt < 10'(c_act_w)) && (lineCnt < 9'(c_act_h));
        w_start    = (pixelCnt == 10'd0) && (lineCnt == 9'd0);
        w_tm_eff   = w_start ? testMode : r_tm_lat_q;
        w_tm_lat_d = w_tm_eff;
        w_addr_d   = w_visible ? w_addr_calc : r_mem_addr_q;
        w_rd_en_d  = w_visible & ~w_tm_eff;
    end

    vga_delay_line #(
        .WIDTH     (3),
        .DEPTH     (c_lat),
        .RESET_VAL ({~HPL, ~VPL, 1'b0})
    ) u_sync_dly (
        .clk    (clock),
        .rst    (reset),
        .i_data ({hSync, vSync, w_start}),
        .o_data ({vgaHSync, vgaVSync, frameStart})
    );

    // One stage shorter: the RGB output register supplies the final cycle
    vga_delay_line #(
        .WIDTH     (5),
        .DEPTH     (RD_LAT + 1),
        .RESET_VAL (5'b10000)
    ) u_pix_dly (
        .clk    (clock),
        .rst    (reset),
        .i_data ({~w_visible, w_tm_eff, w_bar}),
        .o_data ({w_blank_dly, w_tm_dly, w_bar_dly})
    );

    always_comb begin
        w_red_d   = 3'd0;
        w_green_d = 3'd0;
        w_blue_d  = 2'd0;
        if (!w_blank_dly) begin
            if (w_tm_dly) begin
                w_red_d   = {3{w_bar_dly[2]}};
                w_green_d = {3{w_bar_dly[1]}};
                w_blue_d  = {2{w_bar_dly[0]}};
            end else begin
                w_red_d   = memData[R_MSB:R_LSB];
                w_green_d = memData[G_MSB:G_LSB];
                w_blue_d  = memData[B_MSB:B_LSB];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mem_addr_q  <= 16'd0;
            r_mem_rd_en_q <= 1'b0;
            r_tm_lat_q    <= 1'b0;
            r_red_q       <= 3'd0;
            r_green_q     <= 3'd0;
            r_blue_q      <= 2'd0;
        end else begin
            r_mem_addr_q  <= w_addr_d;
            r_mem_rd_en_q <= w_rd_en_d;
            r_tm_lat_q    <= w_tm_lat_d;
            r_red_q       <= w_red_d;
            r_green_q     <= w_green_d;
            r_blue_q      <= w_blue_d;
        end
    end

    assign memAddr  = r_mem_addr_q;
    assign memRdEn  = r_mem_rd_en_q;
    assign vgaRed   = r_red_q;
    assign vgaGreen = r_green_q;
    assign vgaBlue  = r_blue_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pixel_fetch
// Description : Randomized self-checking bench for vga_pixel_fetch against a
//               cycle-indexed reference model of the pixel pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pixel_fetch;

    import vga_pkg::*;

    localparam int RD_LAT = 2;
    localparam int L      = RD_LAT + 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pixelCnt = '0;
    logic [8:0]  lineCnt = '0;
    logic        hSync = 1'b1;
    logic        vSync = 1'b0;
    logic        compBlank = 1'b1;
    logic        testMode = 1'b0;
    logic [15:0] memAddr;
    logic        memRdEn;
    logic [7:0]  memData = '0;
    logic [2:0]  vgaRed;
    logic [2:0]  vgaGreen;
    logic [1:0]  vgaBlue;
    logic        vgaHSync;
    logic        vgaVSync;
    logic        frameStart;

    always #20 clock = ~clock;

    vga_pixel_fetch #(.RD_LAT(RD_LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .pixelCnt   (pixelCnt),
        .lineCnt    (lineCnt),
        .hSync      (hSync),
        .vSync      (vSync),
        .compBlank  (compBlank),
        .testMode   (testMode),
        .memAddr    (memAddr),
        .memRdEn    (memRdEn),
        .memData    (memData),
        .vgaRed     (vgaRed),
        .vgaGreen   (vgaGreen),
        .vgaBlue    (vgaBlue),
        .vgaHSync   (vgaHSync),
        .vgaVSync   (vgaVSync),
        .frameStart (frameStart)
    );

    // What the model says each input cycle must eventually produce
    typedef struct packed {
        logic        rst;
        logic [9:0]  pix;
        logic [8:0]  ln;
        logic [7:0]  rgb;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [15:0] addr;
        logic        en;
    } rec_t;

    rec_t        hist [16];
    logic [7:0]  fb [65536];
    logic [15:0] ram_addr [16];
    logic        ram_en [16];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          tm_lat_m = 1'b0;
    logic [15:0] addr_m = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic step(input int pix, input int ln, input bit tm, input bit rst_in);
        rec_t       e;
        rec_t       r;
        bit         flushed;
        bit         vis;
        bit         start;
        bit         tm_e;
        int         bar;
        int         fb_idx;
        logic [7:0] exp_rgb;
        logic       exp_hs;
        logic       exp_vs;
        logic       exp_fs;

        @(posedge clock);
        #1;

        // Outputs: inputs of cycle cyc-L, unless a reset landed in between
        flushed = 1'b0;
        for (int k = 1; k <= L; k++) begin
            if (cyc - k < 0 || hist[(cyc-k) & 15].rst) flushed = 1'b1;
        end
        if (flushed) begin
            exp_rgb = 8'd0;
            exp_hs  = ~HPL;
            exp_vs  = ~VPL;
            exp_fs  = 1'b0;
        end else begin
            e       = hist[(cyc-L) & 15];
            exp_rgb = e.rgb;
            exp_hs  = e.hs;
            exp_vs  = e.vs;
            exp_fs  = e.fs;
        end
        check_eq("rgb", 32'({vgaRed, vgaGreen, vgaBlue}), 32'(exp_rgb));
        check_eq("hsync", 32'(vgaHSync), 32'(exp_hs));
        check_eq("vsync", 32'(vgaVSync), 32'(exp_vs));
        check_eq("frameStart", 32'(frameStart), 32'(exp_fs));

        // Request side: one cycle after the inputs
        if (cyc == 0 || hist[(cyc-1) & 15].rst) begin
            check_eq("memAddr_rst", 32'(memAddr), 32'd0);
            check_eq("memRdEn_rst", 32'(memRdEn), 32'd0);
        end else begin
            e = hist[(cyc-1) & 15];
            check_eq("memAddr", 32'(memAddr), 32'(e.addr));
            check_eq("memRdEn", 32'(memRdEn), 32'(e.en));
            if (e.pix == 10'd5 && e.ln == 9'd3)
                check_eq("memAddr_p5_l3", 32'(memAddr), 32'd322);
            if (e.pix == 10'd639 && e.ln == 9'd399)
                check_eq("memAddr_last", 32'(memAddr), 32'd63999);
            if (e.pix == 10'd640)
                check_eq("memRdEn_p640", 32'(memRdEn), 32'd0);
        end

        // Fixed-latency RAM; data outside a read is deliberately garbage
        ram_addr[cyc & 15] = memAddr;
        ram_en[cyc & 15]   = memRdEn;
        if (cyc >= RD_LAT && ram_en[(cyc-RD_LAT) & 15])
            memData = fb[ram_addr[(cyc-RD_LAT) & 15]];
        else
            memData = 8'($urandom);

        pixelCnt  = 10'(pix);
        lineCnt   = 9'(ln);
        hSync     = (pix >= HDR + HFP && pix < HDR + HFP + HSP) ? HPL : ~HPL;
        vSync     = (ln >= VDR + VFP && ln < VDR + VFP + VSP) ? VPL : ~VPL;
        compBlank = !(pix < HDR && ln < VDR);
        testMode  = tm;
        reset     = rst_in;

        r     = '0;
        r.rst = rst_in;
        r.pix = 10'(pix);
        r.ln  = 9'(ln);
        if (rst_in) begin
            tm_lat_m = 1'b0;
            addr_m   = 16'd0;
        end else begin
            vis   = !compBlank && pix < 640 && ln < 400;
            start = (pix == 0 && ln == 0);
            if (start) tm_lat_m = tm;
            tm_e   = tm_lat_m;
            fb_idx = (ln / 2) * FB_W + pix / 2;
            if (vis) addr_m = 16'(fb_idx);
            r.addr = addr_m;
            r.en   = vis && !tm_e;
            if (!vis) begin
                r.rgb = 8'd0;
            end else if (tm_e) begin
                bar   = pix / 80;
                r.rgb = {((bar & 4) != 0) ? 3'b111 : 3'b000,
                         ((bar & 2) != 0) ? 3'b111 : 3'b000,
                         ((bar & 1) != 0) ? 2'b11  : 2'b00};
            end else begin
                r.rgb = fb[fb_idx];
            end
            r.hs = hSync;
            r.vs = vSync;
            r.fs = start;
        end
        hist[cyc & 15] = r;
        cyc++;
    endtask

    // mode: 0 = testMode low, 1 = high, 2 = random per cycle
    task automatic run_line(input int ln, input int mode, input int rst_pix, input int rst_len);
        bit tm;
        bit rs;
        for (int p = 0; p < 800; p++) begin
            tm = (mode == 2) ? 1'($urandom) : (mode == 1);
            rs = (rst_pix >= 0 && p >= rst_pix && p < rst_pix + rst_len);
            step(p, ln, tm, rs);
        end
    endtask

    initial begin
        int ln;
        int rp;
        for (int i = 0; i < 65536; i++) fb[i] = 8'($urandom);

        for (int i = 0; i < 6; i++) step(790 + i, 448, 1'b0, 1'b1);

        for (int i = 0; i < 4; i++) run_line(i, 0, -1, 0);
        run_line(100, 1, -1, 0);
        run_line(199, 1, -1, 0);
        run_line(399, 1, -1, 0);
        for (int i = 410; i < 416; i++) run_line(i, 1, -1, 0);
        run_line(448, 1, -1, 0);

        run_line(0, 1, -1, 0);
        run_line(1, 2, -1, 0);
        run_line(150, 2, -1, 0);
        run_line(399, 2, -1, 0);
        run_line(448, 2, -1, 0);

        run_line(0, 0, -1, 0);
        run_line(250, 0, 300, 2);
        run_line(251, 0, -1, 0);
        run_line(448, 0, -1, 0);
        run_line(0, 0, -1, 0);

        for (int i = 0; i < 12; i++) begin
            ln = $urandom_range(0, 448);
            if ($urandom_range(0, 3) == 0) ln = 0;
            rp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 799)) : -1;
            run_line(ln, int'($urandom_range(0, 2)), rp, int'($urandom_range(1, 3)));
        end

        for (int i = 0; i < 2 * L; i++) step(700, 448, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
Downstream of the VGA timing generator, this block turns that generator's pixel/line counters and sync/blank signals into RGB pixels. It doubles a 320x200 RGB332 framebuffer to fill the 640x400 display region. It issues read requests to a fixed-latency framebuffer RAM and delays hSync/vSync so they stay aligned with the returned pixel data. A frame-latched colour-bar test mode lets the monitor be brought up without memory.

Parameters:
FB_W, 320, framebuffer width in pixels
FB_H, 200, framebuffer height in lines
RD_LAT, 2, RAM read latency in cycles (≥1) from memAddr/memRdEn to memData
HPL, 0, active level of hSync (used for reset fill of the delay line)
VPL, 1, active level of vSync (used for reset fill of the delay line)

Ports:
clock  in  1  pixel clock (25 MHz)
reset  in  1  synchronous, active-high reset
pixelCnt  in  10  pixel counter from the timing generator, 0..799
lineCnt  in  9  line counter from the timing generator, 0..448
hSync  in  1  horizontal sync from the timing generator
vSync  in  1  vertical sync from the timing generator
compBlank  in  1  composite blank from the timing generator, 1 = outside the display region
testMode  in  1  request colour-bar pattern instead of framebuffer data
memAddr  out  16  framebuffer byte address
memRdEn  out  1  read strobe to the framebuffer RAM
memData  in  8  RGB332 pixel data from the RAM, valid RD_LAT cycles after the request
vgaRed  out  3  red output to the DAC
vgaGreen  out  3  green output to the DAC
vgaBlue  out  2  blue output to the DAC
vgaHSync  out  1  delayed hSync
vgaVSync  out  1  delayed vSync
frameStart  out  1  one-cycle pulse on output pixel (0,0)

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values:
  - memAddr=0, memRdEn=0.
  - vgaRed, vgaGreen and vgaBlue are all 0.
  - vgaHSync=~HPL (1), vgaVSync=~VPL (0), frameStart=0.
  - Every delay-line stage is filled with these inactive values and blank=1.
  - The latched test mode (tmLat) resets to 0.
- Total latency L = RD_LAT+2. Inputs sampled in cycle n appear on the vga* outputs in cycle n+L.
- Stage A, registered at the end of cycle n:
  - visible = ~compBlank & pixelCnt<640 & lineCnt<400. The counter checks are defensive.
  - memAddr = (lineCnt>>1)*FB_W + (pixelCnt>>1), computed in 16 bits; maximum value 63999.
  - When not visible, memAddr holds its previous value.
  - memRdEn = visible & ~tmLat.
- memData corresponding to the stage-A request is valid in cycle n+1+RD_LAT.
- Output register, at the end of cycle n+1+RD_LAT:
  - If the delayed blank is 1: RGB = 0.
  - Else if the delayed tmLat is 1: colour bars from the delayed bar = pixelCnt/80 (0..7). Red = {3{bar[2]}}, green = {3{bar[1]}}, blue = {2{bar[0]}}.
  - Else: red = memData[7:5], green = memData[4:2], blue = memData[1:0].
- Sync, blank, bar index and frameStart each pass through an L-deep (or matching-depth) shift register.
  - No polarity change and no glitches.
  - Width preserved: 96 cycles for hSync low, 2 lines for vSync high.
- tmLat loads testMode only in the cycle where pixelCnt==0 && lineCnt==0. A mid-frame testMode change therefore never tears the image.
- frameStart source = (pixelCnt==0 && lineCnt==0), delayed by L.
- Each framebuffer pixel is read twice per line and each line is read on two consecutive scanlines. No line buffer; the RAM must sustain one read per clock.
- Reset mid-frame: the pipeline flushes to inactive values immediately. After release, outputs track the inputs with latency L. Counters come from upstream, so no resynchronisation is needed.
- The same RAM word read on consecutive cycles is legal. The read strobe is never suppressed during the visible region in framebuffer mode.

Decomposition:
- Shared package vga_pkg holds:
  - Timing constants HDR/HFP/HSP/HBP/VDR/VFP/VSP/VBP.
  - Polarities HPL/VPL.
  - FB_W/FB_H and the RGB332 field positions (R 7:5, G 4:2, B 1:0).
- One sub-module, vga_delay_line: parameters WIDTH, DEPTH and RESET_VAL. It is a synchronous-reset shift register used for the sync/blank/bar/frameStart alignment.

Test Plan:
1. Reset, then a free-running timing generator with RD_LAT=2 → for 4 cycles after reset, vgaHSync=1, vgaVSync=0 and RGB=0; vgaHSync first falls 4 cycles after pixelCnt reaches 656.
2. RAM model returns memData=addr[7:0] → at input (pixel 5, line 3): memAddr=1*320+2=322, memRdEn=1. Output 4 cycles later = 0x42 → R=2, G=0, B=2.
3. Input pixel 639, line 399 → memAddr=63999. At pixel 640, memRdEn=0 and output RGB is 0 from L cycles later through the blanking interval.
4. testMode=1 asserted at line 100 → image unchanged until the next (0,0). Then pixel 85 shows bar 1 (R=0, G=0, B=3), pixel 600 shows bar 7 (all ones), and memRdEn stays 0 all frame.
5. Reset pulsed at pixel 300, line 250 → the next cycle shows inactive outputs. After release, frameStart pulses exactly L cycles after the next (0,0).
6. RD_LAT=1 and RD_LAT=4 builds → vgaHSync low width is 96 clocks, vgaVSync high width is 1600 clocks, and the RGB-to-sync offset is identical to the zero-latency reference.
